// File: rtl/snn_mem_pkg.sv
// rtl/snn_mem_pkg.sv - shared clear-FSM type and byte helpers for dp_ram_clr
package snn_mem_pkg;

   typedef enum logic {IDLE, CLEAR} clr_state_t;

   // one byte lane of a partial write: new byte where enabled, old byte otherwise
   function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       we);
      return we ? new_b : old_b;
   endfunction

   // even-parity bit for one byte (stored bit makes the 9-bit total even)
   function automatic logic parity8(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/dp_ram_clr_if.sv
// rtl/dp_ram_clr_if.sv - port A/B access and clear-control bundle for dp_ram_clr
interface dp_ram_clr_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                    a_en;
   logic [DATA_WIDTH/8-1:0] a_we;
   logic [ADDR_WIDTH-1:0]   a_addr;
   logic [DATA_WIDTH-1:0]   a_din;
   logic [DATA_WIDTH-1:0]   a_dout;
   logic                    a_vld;
   logic                    b_en;
   logic [ADDR_WIDTH-1:0]   b_addr;
   logic [DATA_WIDTH-1:0]   b_dout;
   logic                    b_vld;
   logic                    clr_req;
   logic                    busy;
`ifdef DP_RAM_PARITY_EN
   logic                    a_perr;
   logic                    b_perr;
   logic                    inj_perr;
`endif

   modport master (
      output a_en, a_we, a_addr, a_din, b_en, b_addr, clr_req,
`ifdef DP_RAM_PARITY_EN
      output inj_perr,
      input  a_perr, b_perr,
`endif
      input  a_dout, a_vld, b_dout, b_vld, busy
   );

   modport slave (
      input  a_en, a_we, a_addr, a_din, b_en, b_addr, clr_req,
`ifdef DP_RAM_PARITY_EN
      input  inj_perr,
      output a_perr, b_perr,
`endif
      output a_dout, a_vld, b_dout, b_vld, busy
   );
endinterface

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - LAT-stage delay of {vld, data}; data holds when vld is low
module ram_rd_pipe #(
   parameter int LAT = 1,
   parameter int W   = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   input  logic [W-1:0] in_data,
   output logic         out_vld,
   output logic [W-1:0] out_data
);
   logic [LAT-1:0]        vld_q, vld_d;
   logic [LAT-1:0][W-1:0] data_q, data_d;

   // each stage loads from the one before it only when that stage is valid
   always_comb begin
      vld_d     = vld_q;
      data_d    = data_q;
      vld_d[0]  = in_vld;
      data_d[0] = in_vld ? in_data : data_q[0];
      for (int i = 1; i < LAT; i++) begin
         vld_d[i]  = vld_q[i-1];
         data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
      end
   end

   // pipeline registers, flushed by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign out_vld  = vld_q[LAT-1];
   assign out_data = data_q[LAT-1];
endmodule

// File: rtl/dp_ram_clr.sv
// rtl/dp_ram_clr.sv - dual-port RAM with clear engine; DP_RAM_PARITY_EN adds byte parity
module dp_ram_clr
   import snn_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int RD_LATENCY  = 1,
   parameter int WRITE_FIRST = 0,
   parameter int CLR_ON_RST  = 1
) (
   input logic         clk,
   input logic         rst_n,
   dp_ram_clr_if.slave bus
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int NB    = DATA_WIDTH/8;
`ifdef DP_RAM_PARITY_EN
   localparam int PW    = DATA_WIDTH + 1;
`else
   localparam int PW    = DATA_WIDTH;
`endif

   clr_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
   logic                  started_q, started_d;
   logic                  kick, busy, a_acc, b_acc, a_wr, b_merge_sel;
   logic [NB-1:0]         wr_be;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data, a_rd, b_old, b_rd;
   logic [PW-1:0]         a_pipe_in, b_pipe_in, a_pipe_out, b_pipe_out;
   logic                  a_vld, b_vld;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // kick is the first post-reset cycle: it already clears word 0 so the sweep is DEPTH cycles
   assign kick = (CLR_ON_RST != 0) & ~started_q;

   // clear FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         clr_addr_q <= '0;
         started_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         started_q  <= started_d;
      end
   end

   // clear FSM next state; clr_addr wraps back to 0 after the last word
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      started_d  = 1'b1;
      case (state_q)
         IDLE: begin
            if (kick) begin
               clr_addr_d = clr_addr_q + 1'b1;
               state_d    = CLEAR;
            end else if (bus.clr_req) begin
               state_d    = CLEAR;
            end
         end
         CLEAR: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == ADDR_WIDTH'(DEPTH-1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: busy gating of user ports and selection of the single write port
   always_comb begin
      busy  = (state_q == CLEAR) | kick;
      a_acc = bus.a_en & ~busy;
      b_acc = bus.b_en & ~busy;
      a_wr  = a_acc & (|bus.a_we);
      if (busy) begin
         wr_be   = '1;
         wr_addr = clr_addr_q;
         wr_data = '0;
      end else begin
         wr_be   = a_acc ? bus.a_we : '0;
         wr_addr = bus.a_addr;
         wr_data = bus.a_din;
      end
   end

   assign bus.busy = busy;

   // read words sampled before this cycle's write; write-first merge on port B collision
   always_comb begin
      a_rd        = mem[bus.a_addr];
      b_old       = mem[bus.b_addr];
      b_merge_sel = (WRITE_FIRST != 0) & a_wr & (bus.a_addr == bus.b_addr);
      for (int i = 0; i < NB; i++) begin
         b_rd[i*8 +: 8] = b_merge_sel ? byte_merge(b_old[i*8 +: 8], bus.a_din[i*8 +: 8], bus.a_we[i])
                                      : b_old[i*8 +: 8];
      end
   end

`ifdef DP_RAM_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];
   logic [NB-1:0] wr_par, a_pbad, b_pbad;
   logic          inj_q, inj_d, a_perr_raw, b_perr_raw;

   // parity generation (with one-shot injection) and read-side mismatch detection
   always_comb begin
      inj_d = (inj_q & ~a_wr) | bus.inj_perr;
      for (int i = 0; i < NB; i++) begin
         wr_par[i] = parity8(wr_data[i*8 +: 8]) ^ (inj_q & a_wr);
         a_pbad[i] = parity8(a_rd[i*8 +: 8]) ^ par_mem[bus.a_addr][i];
         b_pbad[i] = parity8(b_old[i*8 +: 8]) ^ par_mem[bus.b_addr][i];
      end
      a_perr_raw = |a_pbad;
      b_perr_raw = b_merge_sel ? |(b_pbad & ~bus.a_we) : |b_pbad;
   end

   // pending parity-injection flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inj_q <= 1'b0;
      else        inj_q <= inj_d;
   end

   assign a_pipe_in = {a_perr_raw, a_rd};
   assign b_pipe_in = {b_perr_raw, b_rd};
`else
   assign a_pipe_in = a_rd;
   assign b_pipe_in = b_rd;
`endif

   // storage write; no reset so contents survive rst_n
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (wr_be[i]) begin
            mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
`ifdef DP_RAM_PARITY_EN
            par_mem[wr_addr][i]    <= wr_par[i];
`endif
         end
      end
   end

   ram_rd_pipe #(.LAT(RD_LATENCY), .W(PW)) u_pipe_a (
      .clk(clk), .rst_n(rst_n), .in_vld(a_acc), .in_data(a_pipe_in),
      .out_vld(a_vld), .out_data(a_pipe_out)
   );

   ram_rd_pipe #(.LAT(RD_LATENCY), .W(PW)) u_pipe_b (
      .clk(clk), .rst_n(rst_n), .in_vld(b_acc), .in_data(b_pipe_in),
      .out_vld(b_vld), .out_data(b_pipe_out)
   );

   assign bus.a_vld  = a_vld;
   assign bus.b_vld  = b_vld;
   assign bus.a_dout = a_pipe_out[DATA_WIDTH-1:0];
   assign bus.b_dout = b_pipe_out[DATA_WIDTH-1:0];
`ifdef DP_RAM_PARITY_EN
   assign bus.a_perr = a_pipe_out[DATA_WIDTH] & a_vld;
   assign bus.b_perr = b_pipe_out[DATA_WIDTH] & b_vld;
`endif
endmodule

// File: tb/tb_dp_ram_clr.sv
// tb/tb_dp_ram_clr.sv - scoreboard bench for dp_ram_clr (default and latency-2/write-first builds)
module tb_dp_ram_clr;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
      bit          perr;
   } exp_t;

   exp_t        q [4][$];
   logic [31:0] m0 [1024];
   logic [31:0] m1 [16];

   dp_ram_clr_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) i0 ();
   dp_ram_clr_if #(.ADDR_WIDTH(4),  .DATA_WIDTH(32)) i1 ();

   dp_ram_clr #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RD_LATENCY(1), .WRITE_FIRST(0), .CLR_ON_RST(1))
      u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
   dp_ram_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(2), .WRITE_FIRST(1), .CLR_ON_RST(1))
      u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] bmerge(logic [31:0] old, logic [31:0] din, logic [3:0] we);
      logic [31:0] mask;
      mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
      return (old & ~mask) | (din & mask);
   endfunction

   // ports 0/1: u0 A/B (latency 1); ports 2/3: u1 A/B (latency 2)
   task automatic push(int p, logic [31:0] d, bit pe);
      q[p].push_back('{data: d, cyc: cyc + ((p < 2) ? 1 : 2), perr: pe});
   endtask

   task automatic mon(int p, logic vld, logic [31:0] d, logic pe);
      exp_t e;
      if (vld === 1'b1) begin
         checks++;
         if (q[p].size() == 0) begin
            errors++;
            $display("FAIL vld_unexpected port%0d got %h at cyc %0d expected no vld", p, d, cyc);
         end else begin
            e = q[p].pop_front();
            if (d !== e.data || cyc != e.cyc || pe !== e.perr) begin
               errors++;
               $display("FAIL rd_port%0d got %h/cyc%0d/perr%0b expected %h/cyc%0d/perr%0b",
                        p, d, cyc, pe, e.data, e.cyc, e.perr);
            end
         end
      end
   endtask

   // monitor: pops and compares whenever a vld strobe is presented
   always @(negedge clk) begin
`ifdef DP_RAM_PARITY_EN
      mon(0, i0.a_vld, i0.a_dout, i0.a_perr);
      mon(1, i0.b_vld, i0.b_dout, i0.b_perr);
      mon(2, i1.a_vld, i1.a_dout, i1.a_perr);
      mon(3, i1.b_vld, i1.b_dout, i1.b_perr);
`else
      mon(0, i0.a_vld, i0.a_dout, 1'b0);
      mon(1, i0.b_vld, i0.b_dout, 1'b0);
      mon(2, i1.a_vld, i1.a_dout, 1'b0);
      mon(3, i1.b_vld, i1.b_dout, 1'b0);
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(int k, bit ae, logic [3:0] we, int aa, logic [31:0] ad, bit be, int ba);
      if (k == 0) begin
         i0.a_en = ae; i0.a_we = we; i0.a_addr = 10'(aa); i0.a_din = ad;
         i0.b_en = be; i0.b_addr = 10'(ba);
      end else begin
         i1.a_en = ae; i1.a_we = we; i1.a_addr = 4'(aa); i1.a_din = ad;
         i1.b_en = be; i1.b_addr = 4'(ba);
      end
      step();
      i0.a_en = 1'b0; i0.b_en = 1'b0;
      i1.a_en = 1'b0; i1.b_en = 1'b0;
   endtask

   task automatic wr(int k, int addr, logic [3:0] we, logic [31:0] din);
      logic [31:0] old;
      old = (k == 0) ? m0[addr] : m1[addr];
      push(2*k, old, 1'b0);
      if (k == 0) m0[addr] = bmerge(old, din, we);
      else        m1[addr] = bmerge(old, din, we);
      drv(k, 1'b1, we, addr, din, 1'b0, 0);
   endtask

   task automatic rd(int k, int addr);
      push(2*k + 1, (k == 0) ? m0[addr] : m1[addr], 1'b0);
      drv(k, 1'b0, 4'h0, 0, 32'h0, 1'b1, addr);
   endtask

   task automatic reset_seq(string tag);
      int n0, n1;
      rst_n = 1'b0;
      step();
      step();
      chk({tag, "_a_dout"}, i0.a_dout, 32'h0);
      chk({tag, "_b_dout"}, i0.b_dout, 32'h0);
      chk({tag, "_a_vld"},  {31'h0, i0.a_vld}, 32'h0);
      chk({tag, "_b_vld"},  {31'h0, i0.b_vld}, 32'h0);
      chk({tag, "_u1_b_dout"}, i1.b_dout, 32'h0);
      rst_n = 1'b1;
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         n0 += int'(i0.busy);
         n1 += int'(i1.busy);
         if (!i0.busy && !i1.busy) break;
      end
      chk({tag, "_busy_cycles_u0"}, n0, 32'd1024);
      chk({tag, "_busy_cycles_u1"}, n1, 32'd16);
      step();
      for (int i = 0; i < 1024; i++) m0[i] = 32'h0;
      for (int i = 0; i < 16; i++)   m1[i] = 32'h0;
   endtask

   initial begin
      int nb;
      i0.a_en = 0; i0.a_we = 0; i0.a_addr = 0; i0.a_din = 0; i0.b_en = 0; i0.b_addr = 0; i0.clr_req = 0;
      i1.a_en = 0; i1.a_we = 0; i1.a_addr = 0; i1.a_din = 0; i1.b_en = 0; i1.b_addr = 0; i1.clr_req = 0;
`ifdef DP_RAM_PARITY_EN
      i0.inj_perr = 0;
      i1.inj_perr = 0;
`endif
      #1;
      reset_seq("rst");

      rd(0, 0); rd(0, 511); rd(0, 1023);

      // byte-enable write and read-first own-port data
      wr(0, 5, 4'hF, 32'hDEADBEEF);
      wr(0, 5, 4'b0010, 32'h00001200);
      rd(0, 5);
      chk("model_partial_write", m0[5], 32'hDEAD12EF);

      // collision on u0 (read-old)
      wr(0, 7, 4'hF, 32'h11111111);
      push(0, 32'h11111111, 1'b0);
      push(1, 32'h11111111, 1'b0);
      m0[7] = 32'h22222222;
      drv(0, 1'b1, 4'hF, 7, 32'h22222222, 1'b1, 7);
      rd(0, 7);

      // u1: latency 2, back-to-back reads 0..7
      for (int i = 0; i < 8; i++) wr(1, i, 4'hF, i);
      for (int i = 0; i < 8; i++) rd(1, i);

      // collision on u1 (write-first), full and partial
      wr(1, 7, 4'hF, 32'h11111111);
      push(2, 32'h11111111, 1'b0);
      push(3, 32'h22222222, 1'b0);
      m1[7] = 32'h22222222;
      drv(1, 1'b1, 4'hF, 7, 32'h22222222, 1'b1, 7);
      push(2, 32'h22222222, 1'b0);
      push(3, 32'h222222AB, 1'b0);
      m1[7] = 32'h222222AB;
      drv(1, 1'b1, 4'b0001, 7, 32'h000000AB, 1'b1, 7);
      rd(1, 7);

      // clear request with coincident access, then ignored accesses during the sweep
      for (int i = 0; i < 16; i++) wr(1, i, 4'hF, 32'hA5A5A5A5);
      i1.clr_req = 1'b1;
      wr(1, 3, 4'hF, 32'h12345678);
      i1.clr_req = 1'b0;
      for (int i = 0; i < 16; i++) m1[i] = 32'h0;
      nb = 0;
      for (int i = 0; i < 40 && i1.busy; i++) begin
         nb++;
         i1.clr_req = (i == 5);
         drv(1, 1'b1, 4'hF, 0, 32'hFFFFFFFF, 1'b1, i % 16);
      end
      i1.clr_req = 1'b0;
      chk("clr_busy_cycles_u1", nb, 32'd16);
      for (int i = 0; i < 16; i++) rd(1, i);

      // reset in the middle of a u0 sweep restarts a full sweep
      i0.clr_req = 1'b1;
      step();
      i0.clr_req = 1'b0;
      repeat (300) step();
      repeat (4) step();
      reset_seq("midrst");
      rd(0, 5);
      rd(1, 7);

`ifdef DP_RAM_PARITY_EN
      i0.inj_perr = 1'b1;
      step();
      i0.inj_perr = 1'b0;
      wr(0, 9, 4'hF, 32'hCAFEF00D);
      push(0, 32'hCAFEF00D, 1'b1);
      push(1, 32'hCAFEF00D, 1'b1);
      drv(0, 1'b1, 4'h0, 9, 32'h0, 1'b1, 9);
      push(0, 32'hCAFEF00D, 1'b1);
      m0[9] = 32'h0BADBEEF;
      drv(0, 1'b1, 4'hF, 9, 32'h0BADBEEF, 1'b0, 0);
      rd(0, 9);
`endif

      repeat (6) step();
      for (int p = 0; p < 4; p++) chk($sformatf("queue_drained_port%0d", p), q[p].size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
